// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the memory stage: write-back select legs and the
// data-memory handshake FSM states.
package mem_wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU   = 2'b00,
        WB_MEM   = 2'b01,
        WB_SHIFT = 2'b10,
        WB_LINK  = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/mem_wb_stage_dmem_handshake_fsm.sv
// req/ack handshake to a variable-latency data memory with a timeout abort.
// Owns the dmem_* request registers, the captured read data and the stall.
module dmem_handshake_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int                DATA_W         = 16,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] ERR_DATA       = 16'hDEAD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] rdata_q,
    output logic              mem_error,
    output logic              stall_mem
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             start, ack_hit, timeout, stall_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        start   = 1'b0;
        ack_hit = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    stall_c = 1'b1;
                    start   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    ack_hit = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gated by reset so the freeze releases asynchronously even if a load sits upstream.
    assign stall_mem = reset & stall_c;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rdata_q    <= '0;
            mem_error  <= 1'b0;
        end else begin
            cnt_q <= (state_q == ACCESS && state_d == ACCESS) ? cnt_q + 1'b1 : '0;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write;
                dmem_addr  <= addr;
                dmem_wdata <= store_data;
            end
            if (ack_hit) begin
                dmem_req <= 1'b0;
                rdata_q  <= dmem_we ? '0 : dmem_rdata;
            end
            if (timeout) begin
                dmem_req  <= 1'b0;
                rdata_q   <= ERR_DATA;
                mem_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register: drives the data-memory handshake,
// selects the write-back value and bubbles the register-file write while stalled.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int                DATA_W         = 16,
    parameter int                REG_ADDR_W     = 4,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] ERR_DATA       = 16'hDEAD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [1:0]            ex_write_back,
    input  logic [DATA_W-1:0]     ex_alu_out,
    input  logic [DATA_W-1:0]     ex_shift_out,
    input  logic [DATA_W-1:0]     ex_link_pc,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_write_addr,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  stall_mem,
    output logic                  mem_error,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_write_addr,
    output logic [DATA_W-1:0]     wb_write_data
);

    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] wb_value;

    dmem_handshake_fsm #(
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .ERR_DATA      (ERR_DATA)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (ex_mem_read),
        .mem_write (ex_mem_write),
        .addr      (ex_alu_out),
        .store_data(ex_store_data),
        .dmem_ack  (dmem_ack),
        .dmem_rdata(dmem_rdata),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .rdata_q   (rdata_q),
        .mem_error (mem_error),
        .stall_mem (stall_mem)
    );

    always_comb begin
        wb_value = ex_alu_out;
        case (wb_sel_e'(ex_write_back))
            WB_ALU:   wb_value = ex_alu_out;
            WB_MEM:   wb_value = ex_mem_read ? rdata_q : '0;
            WB_SHIFT: wb_value = ex_shift_out;
            WB_LINK:  wb_value = ex_link_pc;
            default:  wb_value = ex_alu_out;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_reg_write  <= 1'b0;
            wb_write_addr <= '0;
            wb_write_data <= '0;
        end else if (stall_mem) begin
            wb_reg_write <= 1'b0;
        end else begin
            wb_reg_write  <= ex_reg_write;
            wb_write_addr <= ex_write_addr;
            wb_write_data <= wb_value;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios, a vector table of
// non-memory ops, and randomized ops scored against a behavioural model.
module tb_mem_wb_stage;

    typedef struct {
        logic        rw;
        logic        rd;
        logic        wr;
        logic [1:0]  sel;
        logic [15:0] alu;
        logic [15:0] shift;
        logic [15:0] link;
        logic [15:0] sdata;
        logic [3:0]  waddr;
    } op_t;

    typedef struct {
        op_t         op;
        logic [15:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [1:0]  ex_write_back = 2'b00;
    logic [15:0] ex_alu_out = '0, ex_shift_out = '0, ex_link_pc = '0, ex_store_data = '0;
    logic [3:0]  ex_write_addr = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic        stall_mem, mem_error, wb_reg_write;
    logic [3:0]  wb_write_addr;
    logic [15:0] wb_write_data;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] last_data = '0;
    logic        model_err = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_write_back(ex_write_back), .ex_alu_out(ex_alu_out), .ex_shift_out(ex_shift_out),
        .ex_link_pc(ex_link_pc), .ex_store_data(ex_store_data), .ex_write_addr(ex_write_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
        .mem_error(mem_error), .wb_reg_write(wb_reg_write),
        .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic rw, input logic rd, input logic wr, input logic [1:0] sel,
                               input logic [15:0] alu, input logic [15:0] shift, input logic [15:0] link,
                               input logic [15:0] sdata, input logic [3:0] waddr);
        op_t o;
        o.rw = rw; o.rd = rd; o.wr = wr; o.sel = sel; o.alu = alu;
        o.shift = shift; o.link = link; o.sdata = sdata; o.waddr = waddr;
        return o;
    endfunction

    task automatic apply(input op_t o);
        ex_reg_write  = o.rw;
        ex_mem_read   = o.rd;
        ex_mem_write  = o.wr;
        ex_write_back = o.sel;
        ex_alu_out    = o.alu;
        ex_shift_out  = o.shift;
        ex_link_pc    = o.link;
        ex_store_data = o.sdata;
        ex_write_addr = o.waddr;
    endtask

    // Behavioural model: memory ack arrives in the ack_at-th request cycle (0 = never);
    // an access that sees no ack within 16 request cycles is aborted with 16'hDEAD.
    function automatic logic timed_out(input op_t o, input int ack_at);
        return (o.rd | o.wr) && !(ack_at >= 1 && ack_at <= 16);
    endfunction

    function automatic logic [15:0] model_data(input op_t o, input int ack_at, input logic [15:0] rdata);
        logic [15:0] memval;
        if (timed_out(o, ack_at)) memval = 16'hDEAD;
        else if (o.wr)            memval = 16'h0000;
        else                      memval = rdata;
        case (o.sel)
            2'd0:    return o.alu;
            2'd1:    return o.rd ? memval : 16'h0000;
            2'd2:    return o.shift;
            default: return o.link;
        endcase
    endfunction

    function automatic int model_stall(input op_t o, input int ack_at);
        if (!(o.rd | o.wr)) return 0;
        return timed_out(o, ack_at) ? 17 : 1 + ack_at;
    endfunction

    // Called at a negedge; applies one op and returns at the negedge after its write-back.
    task automatic run_op(input string tag, input op_t o, input int ack_at, input logic [15:0] rdata,
                          input logic [15:0] exp_data, input int exp_stall);
        int   stall_cnt = 0;
        int   acc_cnt = 0;
        logic done = 1'b0;
        apply(o);
        dmem_ack = 1'b0;
        model_err = model_err | timed_out(o, ack_at);
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (!stall_mem) begin
                done = 1'b1;
            end else begin
                stall_cnt++;
                if (c > 0) begin
                    check({tag, " bubble"}, {31'd0, wb_reg_write}, 32'd0);
                    check({tag, " wb_hold"}, {16'd0, wb_write_data}, {16'd0, last_data});
                end
                if (dmem_req) begin
                    acc_cnt++;
                    check({tag, " dmem_we"}, {31'd0, dmem_we}, {31'd0, o.wr});
                    check({tag, " dmem_addr"}, {16'd0, dmem_addr}, {16'd0, o.alu});
                    check({tag, " dmem_wdata"}, {16'd0, dmem_wdata}, {16'd0, o.sdata});
                    dmem_ack   = (acc_cnt == ack_at);
                    dmem_rdata = (acc_cnt == ack_at) ? rdata : 16'($urandom);
                end else begin
                    dmem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!done) check({tag, " stall_timeout"}, 32'd1, 32'd0);
        dmem_ack = 1'b0;
        check({tag, " stall_cycles"}, stall_cnt, exp_stall);
        check({tag, " req_low"}, {31'd0, dmem_req}, 32'd0);
        check({tag, " mem_error"}, {31'd0, mem_error}, {31'd0, model_err});
        @(negedge clk);
        check({tag, " wb_reg_write"}, {31'd0, wb_reg_write}, {31'd0, o.rw});
        check({tag, " wb_write_addr"}, {28'd0, wb_write_addr}, {28'd0, o.waddr});
        check({tag, " wb_write_data"}, {16'd0, wb_write_data}, {16'd0, exp_data});
        last_data = exp_data;
    endtask

    vec_t vecs[6];
    op_t  o;
    op_t  zero_op;

    initial begin
        zero_op = mk(0, 0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        vecs[0] = '{mk(1, 0, 0, 2'd0, 16'hA5A5, 16'h1111, 16'h2222, 16'h0, 4'h1), 16'hA5A5};
        vecs[1] = '{mk(1, 0, 0, 2'd2, 16'hA5A5, 16'h1111, 16'h2222, 16'h0, 4'h2), 16'h1111};
        vecs[2] = '{mk(1, 0, 0, 2'd3, 16'hA5A5, 16'h1111, 16'h2222, 16'h0, 4'hF), 16'h2222};
        vecs[3] = '{mk(1, 0, 0, 2'd1, 16'hA5A5, 16'h1111, 16'h2222, 16'h0, 4'h7), 16'h0000};
        vecs[4] = '{mk(0, 0, 0, 2'd0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 4'h0), 16'hFFFF};
        vecs[5] = '{mk(1, 0, 0, 2'd2, 16'h0, 16'h8001, 16'h0, 16'h0, 4'h9), 16'h8001};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst stall", {31'd0, stall_mem}, 32'd0);
        check("rst mem_error", {31'd0, mem_error}, 32'd0);
        check("rst wb", {11'd0, wb_reg_write, wb_write_addr, wb_write_data}, 32'd0);
        check("rst dmem_bus", {dmem_addr, dmem_wdata}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: ALU op
        run_op("t1", mk(1, 0, 0, 2'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 4'h3), 0, 16'h0, 16'h1234, 0);
        // 2: load with ack in the third request cycle
        run_op("t2", mk(1, 1, 0, 2'd1, 16'h0040, 16'h0, 16'h0, 16'h0, 4'h5), 3, 16'hBEEF, 16'hBEEF, 4);
        // 3: store acked immediately
        run_op("t3", mk(0, 0, 1, 2'd0, 16'h0010, 16'h0, 16'h0, 16'h00AA, 4'h6), 1, 16'h1357, 16'h0010, 2);
        // 6: read+write together, write wins and mem leg yields 0; then link
        run_op("t6a", mk(1, 1, 1, 2'd1, 16'h0020, 16'h0, 16'h0, 16'h0BB0, 4'h8), 2, 16'h5555, 16'h0000, 3);
        run_op("t6b", mk(1, 0, 0, 2'd3, 16'h0, 16'h0, 16'h0102, 16'h0, 4'hE), 0, 16'h0, 16'h0102, 0);
        // ack on the last permitted cycle still completes normally
        run_op("edge16", mk(1, 1, 0, 2'd1, 16'h0030, 16'h0, 16'h0, 16'h0, 4'h2), 16, 16'h4321, 16'h4321, 17);

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, 0, 16'h0, vecs[i].exp_data, 0);

        // 4: load that never gets an ack
        run_op("t4", mk(1, 1, 0, 2'd1, 16'h0050, 16'h0, 16'h0, 16'h0, 4'h4), 0, 16'h0, 16'hDEAD, 17);

        // Randomized ops against the model; mem_error stays sticky across them
        for (int i = 0; i < 40; i++) begin
            int          kind, ack_at;
            logic [15:0] rd_val;
            kind   = $urandom_range(0, 5);
            ack_at = $urandom_range(0, 5);
            rd_val = 16'($urandom);
            o = mk(1'($urandom), (kind == 1 || kind == 3), (kind == 2 || kind == 3), 2'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
            run_op($sformatf("rnd%0d", i), o, ack_at, rd_val,
                   model_data(o, ack_at, rd_val), model_stall(o, ack_at));
        end

        // 5: reset in the middle of an access
        apply(mk(1, 1, 0, 2'd1, 16'h0060, 16'h0, 16'h0, 16'h0, 4'h1));
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("t5 req_before", {31'd0, dmem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5 req_async", {31'd0, dmem_req}, 32'd0);
        check("t5 stall_async", {31'd0, stall_mem}, 32'd0);
        check("t5 mem_error_clr", {31'd0, mem_error}, 32'd0);
        check("t5 wb_clr", {11'd0, wb_reg_write, wb_write_addr, wb_write_data}, 32'd0);
        apply(zero_op);
        @(negedge clk);
        reset = 1'b1;
        model_err = 1'b0;
        last_data = '0;
        dmem_ack = 1'b1;
        dmem_rdata = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t5 stray_ack_req", {31'd0, dmem_req}, 32'd0);
            check("t5 stray_ack_stall", {31'd0, stall_mem}, 32'd0);
        end
        dmem_ack = 1'b0;
        @(negedge clk);
        run_op("t5 post", mk(1, 1, 0, 2'd1, 16'h0070, 16'h0, 16'h0, 16'h0, 4'hC), 2, 16'hC0DE, 16'hC0DE, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
